// File: rtl/tlv5618_spi_responder.sv
// rtl/tlv5618_spi_responder.sv - TLV5618 3-wire serial DAC slave model oversampled on Clk
module tlv5618_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 12
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  nCS,
  input  logic                  SCLK,
  input  logic                  DIN,
  output logic [DATA_WIDTH-1:0] DacAData,
  output logic [DATA_WIDTH-1:0] DacBData,
  output logic [DATA_WIDTH-1:0] BufferData,
  output logic                  Speed,
  output logic                  PowerDown,
  output logic                  FrameValid,
  output logic                  FrameError,
  output logic [7:0]            FrameCount
);

  localparam int FrameBits  = DATA_WIDTH + 4;
  localparam int CountMax   = DATA_WIDTH + 5;
  localparam int CountWidth = $clog2(CountMax + 1);

  typedef enum logic [1:0] {
    Idle,
    Shift,
    Decode
  } stateT;

  stateT                  state;
  logic [SYNC_STAGES-1:0] nCsSync;
  logic [SYNC_STAGES-1:0] sclkSync;
  logic [SYNC_STAGES-1:0] dinSync;
  logic                   nCsHist;
  logic                   sclkHist;
  logic                   dinHist;
  logic [FrameBits-1:0]   shiftReg;
  logic [CountWidth-1:0]  bitCount;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      nCsSync  <= '1;
      sclkSync <= '1;
      dinSync  <= '0;
      nCsHist  <= 1'b1;
      sclkHist <= 1'b1;
      dinHist  <= 1'b0;
    end else begin
      nCsSync  <= {nCsSync[SYNC_STAGES-2:0], nCS};
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], SCLK};
      dinSync  <= {dinSync[SYNC_STAGES-2:0], DIN};
      nCsHist  <= nCsSync[SYNC_STAGES-1];
      sclkHist <= sclkSync[SYNC_STAGES-1];
      dinHist  <= dinSync[SYNC_STAGES-1];
    end
  end

  // dinHist shares its sample instant with sclkHist, the last sample taken while SCLK was still high.
  logic nCsRise;
  logic nCsFall;
  logic sclkFall;
  assign nCsRise  = nCsSync[SYNC_STAGES-1] & ~nCsHist;
  assign nCsFall  = ~nCsSync[SYNC_STAGES-1] & nCsHist;
  assign sclkFall = ~sclkSync[SYNC_STAGES-1] & sclkHist;

  logic                  regR1;
  logic                  regR0;
  logic                  frameOk;
  logic [DATA_WIDTH-1:0] frameData;
  assign regR1     = shiftReg[FrameBits-1];
  assign regR0     = shiftReg[FrameBits-4];
  assign frameData = shiftReg[DATA_WIDTH-1:0];
  assign frameOk   = (bitCount == CountWidth'(FrameBits)) && !(regR1 && regR0);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= Idle;
      shiftReg   <= '0;
      bitCount   <= '0;
      DacAData   <= '0;
      DacBData   <= '0;
      BufferData <= '0;
      Speed      <= 1'b0;
      PowerDown  <= 1'b0;
      FrameValid <= 1'b0;
      FrameError <= 1'b0;
      FrameCount <= '0;
    end else begin
      FrameValid <= 1'b0;
      FrameError <= 1'b0;
      case (state)
        Idle: begin
          if (nCsFall) begin
            state    <= Shift;
            shiftReg <= '0;
            bitCount <= '0;
          end
        end
        Shift: begin
          // A falling SCLK coincident with the closing nCS edge still belongs to this frame.
          if (sclkFall) begin
            shiftReg <= {shiftReg[FrameBits-2:0], dinHist};
            if (bitCount != CountWidth'(CountMax)) bitCount <= bitCount + 1'b1;
          end
          if (nCsRise) state <= Decode;
        end
        Decode: begin
          state <= Idle;
          if (frameOk) begin
            case ({regR1, regR0})
              2'b00: begin
                DacBData   <= frameData;
                BufferData <= frameData;
              end
              2'b01: BufferData <= frameData;
              default: begin
                DacAData <= frameData;
                DacBData <= BufferData;
              end
            endcase
            Speed      <= shiftReg[FrameBits-2];
            PowerDown  <= shiftReg[FrameBits-3];
            FrameValid <= 1'b1;
            FrameCount <= FrameCount + 8'd1;
          end else begin
            FrameError <= 1'b1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_tlv5618_spi_responder.sv
// tb/tb_tlv5618_spi_responder.sv - randomized frame bench for tlv5618_spi_responder with a register-level model
module tb_tlv5618_spi_responder;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        nCS = 1'b1;
  logic        SCLK = 1'b1;
  logic        DIN = 1'b0;
  logic [11:0] DacAData;
  logic [11:0] DacBData;
  logic [11:0] BufferData;
  logic        Speed;
  logic        PowerDown;
  logic        FrameValid;
  logic        FrameError;
  logic [7:0]  FrameCount;

  tlv5618_spi_responder dut (
    .Clk(Clk),
    .reset_n(reset_n),
    .nCS(nCS),
    .SCLK(SCLK),
    .DIN(DIN),
    .DacAData(DacAData),
    .DacBData(DacBData),
    .BufferData(BufferData),
    .Speed(Speed),
    .PowerDown(PowerDown),
    .FrameValid(FrameValid),
    .FrameError(FrameError),
    .FrameCount(FrameCount)
  );

  always #5 Clk = ~Clk;

  int totalChecks = 0;
  int badChecks = 0;
  int cycleCount = 0;
  int validPulses = 0;
  int errorPulses = 0;
  int bothPulses = 0;
  int lastPulseCycle = -100;
  int startCycle = 0;

  logic [11:0] mA = '0;
  logic [11:0] mB = '0;
  logic [11:0] mBuf = '0;
  logic        mSpd = 1'b0;
  logic        mPwr = 1'b0;
  int          mCnt = 0;

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  always @(negedge Clk) begin
    if (FrameValid) validPulses++;
    if (FrameError) errorPulses++;
    if (FrameValid && FrameError) bothPulses++;
    if (FrameValid || FrameError) lastPulseCycle = cycleCount;
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic checkOutputs(input string tag);
    checkValue({tag, ".dacA"}, DacAData, mA);
    checkValue({tag, ".dacB"}, DacBData, mB);
    checkValue({tag, ".buf"}, BufferData, mBuf);
    checkValue({tag, ".spd"}, Speed, mSpd);
    checkValue({tag, ".pwr"}, PowerDown, mPwr);
    checkValue({tag, ".count"}, FrameCount, mCnt);
  endtask

  task automatic doFrame(input string tag, input logic [31:0] frame, input int nbits, input int ph);
    int v0;
    int e0;
    bit ok;
    logic [11:0] d;
    v0 = validPulses;
    e0 = errorPulses;
    nCS = 1'b0;
    waitClk(ph);
    for (int i = nbits - 1; i >= 0; i--) begin
      DIN = frame[i];
      waitClk(ph);
      SCLK = 1'b0;
      waitClk(ph);
      SCLK = 1'b1;
    end
    waitClk(ph);
    nCS = 1'b1;
    startCycle = cycleCount;
    waitClk(8);
    ok = (nbits == 16) && !(frame[15] && frame[12]);
    if (ok) begin
      d = frame[11:0];
      if (!frame[15] && !frame[12]) begin
        mB = d;
        mBuf = d;
      end else if (!frame[15]) begin
        mBuf = d;
      end else begin
        mB = mBuf;
        mA = d;
      end
      mSpd = frame[14];
      mPwr = frame[13];
      mCnt = (mCnt + 1) % 256;
    end
    checkValue({tag, ".validPulses"}, validPulses - v0, ok ? 1 : 0);
    checkValue({tag, ".errorPulses"}, errorPulses - e0, ok ? 0 : 1);
    checkValue({tag, ".latency"}, lastPulseCycle - startCycle, 4);
    checkOutputs(tag);
  endtask

  task automatic doNoise(input int toggles);
    int v0;
    int e0;
    v0 = validPulses;
    e0 = errorPulses;
    for (int i = 0; i < toggles; i++) begin
      DIN = 1'($urandom);
      waitClk(2);
      SCLK = 1'b0;
      waitClk(2);
      SCLK = 1'b1;
    end
    waitClk(8);
    checkValue("noise.pulses", (validPulses - v0) + (errorPulses - e0), 0);
    checkOutputs("noise");
  endtask

  initial begin
    int v0;
    int e0;
    int r;
    int nb;
    logic [31:0] fr;
    logic [31:0] sel;

    waitClk(3);
    checkOutputs("reset");
    checkValue("reset.valid", FrameValid, 0);
    checkValue("reset.error", FrameError, 0);
    reset_n = 1'b1;
    waitClk(4);

    doFrame("f8ABC", 32'h8ABC, 16, 2);
    checkValue("f8ABC.dacA.const", DacAData, 12'hABC);
    checkValue("f8ABC.count.const", FrameCount, 1);

    doFrame("f1123", 32'h1123, 16, 2);
    doFrame("fC456", 32'hC456, 16, 2);
    checkValue("dac12.buf", BufferData, 12'h123);
    checkValue("dac12.dacA", DacAData, 12'h456);
    checkValue("dac12.dacB", DacBData, 12'h123);
    checkValue("dac12.spd", Speed, 1);
    checkValue("dac12.count", FrameCount, 3);

    doFrame("f2777", 32'h2777, 16, 2);
    checkValue("f2777.pwr", PowerDown, 1);
    checkValue("f2777.dacB", DacBData, 12'h777);

    doFrame("f9FFF", 32'h9FFF, 16, 2);
    doFrame("len15", 32'h0000_4321, 15, 2);
    doFrame("len17", 32'h0001_8123, 17, 2);
    doFrame("f8001", 32'h8001, 16, 2);
    checkValue("f8001.dacA", DacAData, 12'h001);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) doNoise($urandom_range(1, 6));
      nb = (r == 1) ? 15 : (r == 2) ? 17 : 16;
      fr = $urandom;
      doFrame("rand", fr, nb, $urandom_range(2, 3));
    end

    v0 = validPulses;
    e0 = errorPulses;
    nCS = 1'b0;
    waitClk(2);
    for (int i = 7; i >= 0; i--) begin
      DIN = 1'($urandom);
      waitClk(2);
      SCLK = 1'b0;
      waitClk(2);
      SCLK = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    mA = '0;
    mB = '0;
    mBuf = '0;
    mSpd = 1'b0;
    mPwr = 1'b0;
    mCnt = 0;
    checkOutputs("midReset");
    nCS = 1'b1;
    SCLK = 1'b1;
    waitClk(3);
    reset_n = 1'b1;
    waitClk(8);
    checkValue("midReset.pulses", (validPulses - v0) + (errorPulses - e0), 0);
    checkOutputs("afterReset");
    doFrame("f8055", 32'h8055, 16, 2);
    checkValue("f8055.dacA", DacAData, 12'h055);
    checkValue("f8055.count", FrameCount, 1);

    while (mCnt != 255) begin
      r = $urandom_range(0, 2);
      sel = (r == 0) ? 32'h0000 : (r == 1) ? 32'h1000 : 32'h8000;
      fr = ($urandom & 32'h6FFF) | sel;
      doFrame("wrap", fr, 16, 2);
    end
    checkValue("wrap.255", FrameCount, 255);
    doFrame("wrapLast", 32'h8123, 16, 2);
    checkValue("wrap.0", FrameCount, 0);

    checkValue("exclusive", bothPulses, 0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
